sample_rate_gen: RTL and testbench

Multi-channel programmable sample-rate generator; successor to the fixed-divisor sample clock divider. Each of NUM_CH channels divides clock_in by a runtime-programmable integer divisor and produces a ~50% duty clock_out and a one-cycle tick strobe. The block sits between the system clock and the per-voice sample engines, so voices can run at independent sample rates. Divisor changes are glitch-free.

---
 rtl/sample_rate_gen_pkg.sv | 14 +
 rtl/sample_rate_chan.sv | 86 ++++++++
 rtl/sample_rate_gen.sv | 59 +++++
 tb/tb_sample_rate_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_rate_gen_pkg.sv
// Shared constants and the per-channel divisor record for sample_rate_gen.
package sample_rate_gen_pkg;

  localparam int DEF_DIV_W       = 28;
  localparam int DEF_DEFAULT_DIV = 1024;
  localparam int MIN_DIV         = 2;

  typedef struct packed {
    logic [DEF_DIV_W-1:0] active_div;
    logic [DEF_DIV_W-1:0] pend_div;
    logic                 pend;
  } chan_cfg_t;

endpackage

// File: rtl/sample_rate_chan.sv
// One sample-rate channel: counter, active/pending divisor, registered clock_out and tick.
// SAMPLE_RATE_GEN_SYNC_EN adds sync_i, which restarts the count and applies any pending divisor.
module sample_rate_chan
  import sample_rate_gen_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             clock_in_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
`ifdef SAMPLE_RATE_GEN_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             pend_o,
  output logic             clock_out_o,
  output logic             tick_o
);

  typedef struct packed {
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend;
  } cfg_t;

  cfg_t             cfg_q, cfg_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             restart;

  always_comb begin
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    wrap    = (cnt_q == cfg_q.active_div - DIV_W'(1));
    restart = 1'b0;
`ifdef SAMPLE_RATE_GEN_SYNC_EN
    restart = sync_i;
`endif
    if (!en_i) begin
      cnt_d = '0;
      if (wr_i) cfg_d.active_div = wr_div_i;
    end else begin
      if (restart || wrap) begin
        // A new period always starts at cnt=0, so switching divisor here cannot make a runt.
        cnt_d  = '0;
        tick_d = !restart;
        if (cfg_q.pend) begin
          cfg_d.active_div = cfg_q.pend_div;
          cfg_d.pend       = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      if (wr_i) begin
        cfg_d.pend     = 1'b1;
        cfg_d.pend_div = wr_div_i;
      end
      clk_d = (cnt_d >= (cfg_d.active_div >> 1));
    end
  end

  always_ff @(posedge clock_in_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      cfg_q  <= '{active_div: DIV_W'(DEFAULT_DIV), pend_div: '0, pend: 1'b0};
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cfg_q  <= cfg_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pend_o      = cfg_q.pend;
  assign clock_out_o = clk_q;
  assign tick_o      = tick_q;

endmodule

// File: rtl/sample_rate_gen.sv
// Multi-channel programmable sample-rate generator: cfg decode, cfg_ready mux, NUM_CH channels.
// Optional SAMPLE_RATE_GEN_SYNC_EN adds sync_req_i for phase-aligning all enabled channels.
module sample_rate_gen
  import sample_rate_gen_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = DEF_DIV_W,
  parameter int  DEFAULT_DIV = DEF_DEFAULT_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in_i,
  input  logic              reset_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [NUM_CH-1:0] ch_en_i,
`ifdef SAMPLE_RATE_GEN_SYNC_EN
  input  logic              sync_req_i,
`endif
  output logic [NUM_CH-1:0] clock_out_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic [NUM_CH-1:0] pend;
  logic [DIV_W-1:0]  div_clamped;
  logic              in_range;
  logic              accept;

  assign in_range    = ({1'b0, cfg_ch_i} < (CH_W+1)'(NUM_CH));
  assign div_clamped = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
  assign accept      = cfg_valid_i && cfg_ready_o;

  // Writes to nonexistent channels are always accepted and dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    if (in_range) cfg_ready_o = !pend[cfg_ch_i];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sample_rate_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clock_in_i (clock_in_i),
      .reset_i    (reset_i),
      .en_i       (ch_en_i[g]),
      .wr_i       (accept && in_range && (cfg_ch_i == CH_W'(g))),
      .wr_div_i   (div_clamped),
`ifdef SAMPLE_RATE_GEN_SYNC_EN
      .sync_i     (sync_req_i),
`endif
      .pend_o     (pend[g]),
      .clock_out_o(clock_out_o[g]),
      .tick_o     (tick_o[g])
    );
  end

endmodule

// File: tb/tb_sample_rate_gen.sv
// Self-checking bench for sample_rate_gen: behavioural period/phase model plus directed literal checks.
module tb_sample_rate_gen;

  localparam int NCH  = 3;
  localparam int DW   = 28;
  localparam int DDIV = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH-1:0] clock_out;
  logic [NCH-1:0] tick;
  logic           sync_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sample_rate_gen #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clock_in_i (clk),
    .reset_i    (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_div_i  (cfg_div),
    .ch_en_i    (ch_en),
`ifdef SAMPLE_RATE_GEN_SYNC_EN
    .sync_req_i (sync_req),
`endif
    .clock_out_o(clock_out),
    .tick_o     (tick)
  );

  // Model: each channel is "phase within its current period" plus divisor bookkeeping.
  int m_div[NCH];
  int m_pdiv[NCH];
  int m_ph[NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];
  bit m_co[NCH];

  function automatic bit m_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = DDIV; m_pdiv[c] = 0; m_ph[c] = 0;
      m_pend[c] = 1'b0; m_tick[c] = 1'b0; m_co[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit acc, hit;
    int val, ch;
    ch  = int'(cfg_ch);
    acc = cfg_valid && m_ready(ch);
    hit = acc && (ch < NCH);
    val = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    for (int c = 0; c < NCH; c++) begin
      if (!ch_en[c]) begin
        m_ph[c] = 0; m_tick[c] = 1'b0; m_co[c] = 1'b0;
        if (hit && ch == c) m_div[c] = val;
      end else begin
        m_tick[c] = 1'b0;
        if (sync_req) begin
          m_ph[c] = 0;
          if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; end
        end else begin
          m_ph[c] = m_ph[c] + 1;
          if (m_ph[c] == m_div[c]) begin
            m_ph[c] = 0;
            m_tick[c] = 1'b1;
            if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; end
          end
        end
        if (hit && ch == c) begin m_pend[c] = 1'b1; m_pdiv[c] = val; end
        m_co[c] = (m_ph[c] >= m_div[c] / 2);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [NCH-1:0] et, ec;
        for (int c = 0; c < NCH; c++) begin
          et[c] = m_tick[c];
          ec[c] = m_co[c];
        end
        chk("model_tick", int'(tick), int'(et));
        chk("model_clock_out", int'(clock_out), int'(ec));
        chk("model_cfg_ready", int'(cfg_ready), int'(m_ready(int'(cfg_ch))));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int div);
    int n;
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = DW'(div);
    #1;
    n = 0;
    while (!cfg_ready && n < 2000) begin
      step();
      n++;
    end
    if (!cfg_ready) chk("write_ready_timeout", 0, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      step();
      if (tick[c]) begin
        n = i;
        return;
      end
    end
  endtask

  // Called right after a tick sample: returns edges to the next tick and high samples seen.
  task automatic period_stats(input int c, input int maxn, output int p, output int h);
    p = -1;
    h = 0;
    for (int i = 1; i <= maxn; i++) begin
      step();
      if (clock_out[c]) h++;
      if (tick[c]) begin
        p = i;
        return;
      end
    end
  endtask

  initial begin
    int n, p, h, both, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_tick", int'(tick), 0);
    chk("rst_clock_out", int'(clock_out), 0);

    // ch0 at the reset divisor
    ch_en[0] = 1'b1;
    wait_tick(0, 1100, n);
    chk("ch0_first_tick", n, 1024);
    period_stats(0, 1100, p, h);
    chk("ch0_period", p, 1024);
    chk("ch0_high", h, 512);

    // ch1 programmed while disabled
    write_cfg(1, 5);
    ch_en[1] = 1'b1;
    wait_tick(1, 20, n);
    chk("ch1_first_tick", n, 5);
    period_stats(1, 20, p, h);
    chk("ch1_period", p, 5);
    chk("ch1_high", h, 3);

    // ch2: 8 -> 3 mid-period, then a stalled second write of 4
    write_cfg(2, 8);
    ch_en[2] = 1'b1;
    wait_tick(2, 20, n);
    chk("ch2_first_tick", n, 8);
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = DW'(3);
    step();
    cfg_div = DW'(4);
    #1;
    chk("ch2_stall_ready", int'(cfg_ready), 0);
    wait_tick(2, 20, n);
    chk("ch2_old_period_rest", n, 5);
    chk("ch2_ready_after_apply", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    wait_tick(2, 20, n);
    chk("ch2_div3_period", n, 2);
    wait_tick(2, 20, n);
    chk("ch2_div4_period", n, 4);

    // clamp of 0 and 1
    ch_en[1] = 1'b0;
    write_cfg(1, 0);
    ch_en[1] = 1'b1;
    wait_tick(1, 10, n);
    chk("clamp0_first_tick", n, 2);
    period_stats(1, 10, p, h);
    chk("clamp0_period", p, 2);
    chk("clamp0_high", h, 1);
    ch_en[1] = 1'b0;
    write_cfg(1, 1);
    ch_en[1] = 1'b1;
    wait_tick(1, 10, n);
    chk("clamp1_first_tick", n, 2);

    // out-of-range channel write
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = DW'(7);
    #1;
    chk("oor_ready", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    wait_tick(1, 10, n);
    period_stats(1, 10, p, h);
    chk("oor_ch1_unchanged", p, 2);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_div   = DW'($urandom_range(0, 9));
      end else begin
        cfg_valid = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) begin
        k = $urandom_range(0, NCH - 1);
        ch_en[k] = ~ch_en[k];
      end
      step();
    end
    cfg_valid = 1'b0;

`ifdef SAMPLE_RATE_GEN_SYNC_EN
    ch_en = '1;
    repeat (1100) step();
    ch_en = '0;
    step();
    write_cfg(0, 4);
    write_cfg(1, 6);
    ch_en[0] = 1'b1;
    repeat ($urandom_range(1, 7)) step();
    ch_en[1] = 1'b1;
    repeat ($urandom_range(3, 20)) step();
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    chk("sync_tick_low", int'(tick[1:0]), 0);
    chk("sync_clock_out_low", int'(clock_out[1:0]), 0);
    both = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (tick[0] && tick[1]) both++;
    end
    chk("sync_coincide", both, 2);
`endif

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
